// File: rtl/dma_peripheral_pkg.sv
// Shared types and constants for the DMA peripheral agent: FSM states, transfer
// modes, FIFO sizing and the FIFO-readiness rule used to raise a DMA request.
package dma_peripheral_pkg;

    localparam int FIFO_DEPTH = 8;
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int COUNT_W    = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQUEST = 2'd1,
        ST_ACTIVE  = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    typedef enum logic {
        MODE_DEV_TO_MEM = 1'b0,   // I/O read cycles drain the FIFO
        MODE_MEM_TO_DEV = 1'b1    // I/O write cycles fill the FIFO
    } mode_e;

    // A request may be raised only if the next DMA byte has somewhere to go.
    function automatic logic fifo_can_serve(mode_e mode, logic [COUNT_W-1:0] count);
        if (mode == MODE_DEV_TO_MEM)
            return count != '0;
        else
            return count != COUNT_W'(FIFO_DEPTH);
    endfunction

endpackage

// File: rtl/dma_peripheral_agent_if.sv
// ISA-style DMA bus signals between the DMA controller (master) and the
// peripheral agent (slave).
interface dma_peripheral_agent_if;

    logic       dma_request;
    logic       dma_acknowledge_n;
    logic       io_read_n;
    logic       io_write_n;
    logic       terminal_count;
    logic [7:0] data_bus_in;
    logic [7:0] data_bus_out;
    logic       data_bus_direction;

    modport master (
        input  dma_request, data_bus_out, data_bus_direction,
        output dma_acknowledge_n, io_read_n, io_write_n, terminal_count, data_bus_in
    );

    modport slave (
        output dma_request, data_bus_out, data_bus_direction,
        input  dma_acknowledge_n, io_read_n, io_write_n, terminal_count, data_bus_in
    );

endinterface

// File: rtl/dma_peripheral_fifo.sv
// 8-entry byte FIFO with show-ahead read data; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module dma_peripheral_fifo
    import dma_peripheral_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               push,
    input  logic [7:0]         push_data,
    input  logic               pop,
    output logic [7:0]         pop_data,
    output logic               full,
    output logic               empty,
    output logic [COUNT_W-1:0] count
);

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == COUNT_W'(FIFO_DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + COUNT_W'(1);
                2'b01:   count <= count - COUNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage has no reset; the pointers and count alone define which entries are valid.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/dma_peripheral_agent.sv
// DMA peripheral agent: raises DRQ, moves one byte per I/O strobe through a shared
// FIFO. Define DMA_PERIPHERAL_DEMAND_MODE_EN to keep DRQ asserted between bytes.
module dma_peripheral_agent
    import dma_peripheral_pkg::*;
(
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   channel_enable,
    input  logic                   transfer_mode,
    dma_peripheral_agent_if.slave  bus,
    input  logic                   local_push_valid,
    input  logic [7:0]             local_push_data,
    output logic                   local_push_ready,
    output logic                   local_pop_valid,
    output logic [7:0]             local_pop_data,
    input  logic                   local_pop_ready,
    output logic                   transfer_done
);

    state_e             state, state_next;
    mode_e              mode_q, mode_next;
    logic               tc_flag, tc_next;
    logic               done_next;
    logic               strobe, strobe_q;
    logic [7:0]         data_in_q;
    logic               complete, tc_hit;
    logic               dma_push, dma_pop;
    logic               fifo_push, fifo_pop;
    logic [7:0]         fifo_head;
    logic               fifo_full, fifo_empty;
    logic [COUNT_W-1:0] fifo_count, count_after;
    logic               bus_phase;

    // The strobe of interest follows the mode latched when the request was raised.
    assign strobe    = (mode_q == MODE_MEM_TO_DEV) ? bus.io_write_n : bus.io_read_n;
    assign complete  = (state == ST_ACTIVE) && !strobe_q && strobe && !bus.dma_acknowledge_n;
    assign tc_hit    = tc_flag || bus.terminal_count;
    assign dma_pop   = complete && (mode_q == MODE_DEV_TO_MEM);
    assign dma_push  = complete && (mode_q == MODE_MEM_TO_DEV);
    assign bus_phase = (state == ST_REQUEST) || (state == ST_ACTIVE);

    assign local_push_ready = (!fifo_full || dma_pop) && !dma_push;
    assign local_pop_valid  = !fifo_empty && !dma_pop;
    assign local_pop_data   = fifo_head;

    assign fifo_push = dma_push || (local_push_valid && local_push_ready);
    assign fifo_pop  = dma_pop  || (local_pop_valid && local_pop_ready);

    assign bus.dma_request        = bus_phase;
    assign bus.data_bus_direction = bus_phase && (mode_q == MODE_DEV_TO_MEM) &&
                                    !bus.dma_acknowledge_n && !bus.io_read_n;
    assign bus.data_bus_out       = bus.data_bus_direction ? fifo_head : 8'h00;

    dma_peripheral_fifo u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (dma_push ? data_in_q : local_push_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_comb begin
        count_after = fifo_count;
        if (fifo_push) count_after = count_after + COUNT_W'(1);
        if (fifo_pop)  count_after = count_after - COUNT_W'(1);
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        mode_next  = mode_q;
        tc_next    = tc_flag;
        done_next  = 1'b0;
        case (state)
            ST_IDLE: begin
                mode_next = mode_e'(transfer_mode);
                tc_next   = 1'b0;
                if (channel_enable && fifo_can_serve(mode_e'(transfer_mode), fifo_count))
                    state_next = ST_REQUEST;
            end
            ST_REQUEST: begin
                if (!channel_enable)
                    state_next = ST_IDLE;
                else if (!bus.dma_acknowledge_n && !strobe)
                    state_next = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (bus.terminal_count) tc_next = 1'b1;
                if (complete) begin
                    if (tc_hit) begin
                        state_next = ST_DONE;
                        done_next  = 1'b1;
                        tc_next    = 1'b0;
                    end else begin
`ifdef DMA_PERIPHERAL_DEMAND_MODE_EN
                        if (channel_enable && fifo_can_serve(mode_q, count_after))
                            state_next = ST_REQUEST;
                        else
                            state_next = ST_IDLE;
`else
                        state_next = ST_IDLE;
`endif
                    end
                end
            end
            ST_DONE: begin
                if (!channel_enable) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            mode_q        <= MODE_DEV_TO_MEM;
            tc_flag       <= 1'b0;
            transfer_done <= 1'b0;
            strobe_q      <= 1'b1;
            data_in_q     <= 8'h00;
        end else begin
            state         <= state_next;
            mode_q        <= mode_next;
            tc_flag       <= tc_next;
            transfer_done <= done_next;
            strobe_q      <= strobe;
            if (!bus.io_write_n && !bus.dma_acknowledge_n)
                data_in_q <= bus.data_bus_in;
        end
    end

endmodule

// File: tb/tb_dma_peripheral_agent.sv
// Directed bench for dma_peripheral_agent: reset, both transfer modes, terminal
// count, FIFO full boundary and reset mid-transfer.
module tb_dma_peripheral_agent;

`ifdef DMA_PERIPHERAL_DEMAND_MODE_EN
    localparam logic DEMAND = 1'b1;
`else
    localparam logic DEMAND = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic       channel_enable;
    logic       transfer_mode;
    logic       local_push_valid;
    logic [7:0] local_push_data;
    logic       local_push_ready;
    logic       local_pop_valid;
    logic [7:0] local_pop_data;
    logic       local_pop_ready;
    logic       transfer_done;

    int checks = 0;
    int errors = 0;

    dma_peripheral_agent_if bus ();

    dma_peripheral_agent dut (
        .clock            (clock),
        .reset            (reset),
        .channel_enable   (channel_enable),
        .transfer_mode    (transfer_mode),
        .bus              (bus),
        .local_push_valid (local_push_valid),
        .local_push_data  (local_push_data),
        .local_push_ready (local_push_ready),
        .local_pop_valid  (local_pop_valid),
        .local_pop_data   (local_pop_data),
        .local_pop_ready  (local_pop_ready),
        .transfer_done    (transfer_done)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Bounded wait for DRQ; an expired bound shows up as a failed comparison.
    task automatic wait_drq(input string tag);
        for (int i = 0; i < 8 && !bus.dma_request; i++) tick();
        check(tag, bus.dma_request, 1'b1);
    endtask

    // One device-to-memory byte: DACK plus a two-cycle IOR pulse, optional TC.
    task automatic dma_read(input string tag, input logic tc, input logic [7:0] expected);
        bus.dma_acknowledge_n = 1'b0;
        bus.io_read_n         = 1'b0;
        bus.terminal_count    = tc;
        #1;
        check({tag, "_data"}, bus.data_bus_out, expected);
        check({tag, "_dir"}, bus.data_bus_direction, 1'b1);
        tick();
        tick();
        bus.io_read_n = 1'b1;
        tick();
        bus.dma_acknowledge_n = 1'b1;
        bus.terminal_count    = 1'b0;
        #1;
    endtask

    initial begin
        reset                 = 1'b1;
        channel_enable        = 1'b0;
        transfer_mode         = 1'b0;
        local_push_valid      = 1'b0;
        local_push_data       = 8'h00;
        local_pop_ready       = 1'b0;
        bus.dma_acknowledge_n = 1'b1;
        bus.io_read_n         = 1'b1;
        bus.io_write_n        = 1'b1;
        bus.terminal_count    = 1'b0;
        bus.data_bus_in       = 8'h00;
        tick();
        tick();
        check("rst_drq", bus.dma_request, 1'b0);
        check("rst_dir", bus.data_bus_direction, 1'b0);
        check("rst_dout", bus.data_bus_out, 8'h00);
        check("rst_done", transfer_done, 1'b0);
        check("rst_pop_valid", local_pop_valid, 1'b0);
        check("rst_push_ready", local_push_ready, 1'b1);
        reset = 1'b0;
        tick();

        // Mode 0: single byte 0xA5 with a three-cycle IOR pulse.
        channel_enable   = 1'b1;
        local_push_valid = 1'b1;
        local_push_data  = 8'hA5;
        #1;
        check("m0_push_ready", local_push_ready, 1'b1);
        tick();
        local_push_valid = 1'b0;
        check("m0_drq_lag", bus.dma_request, 1'b0);
        tick();
        check("m0_drq_rise", bus.dma_request, 1'b1);
        bus.dma_acknowledge_n = 1'b0;
        bus.io_read_n         = 1'b0;
        #1;
        check("m0_dir", bus.data_bus_direction, 1'b1);
        check("m0_dout", bus.data_bus_out, 8'hA5);
        tick();
        tick();
        check("m0_dout_active", bus.data_bus_out, 8'hA5);
        tick();
        bus.io_read_n = 1'b1;
        #1;
        check("m0_dir_release", bus.data_bus_direction, 1'b0);
        tick();
        bus.dma_acknowledge_n = 1'b1;
        #1;
        check("m0_drq_after", bus.dma_request, 1'b0);
        check("m0_fifo_empty", local_pop_valid, 1'b0);

        // Mode 1: DRQ raised on an empty FIFO, byte 0x3C written by IOW.
        transfer_mode = 1'b1;
        tick();
        check("m1_drq_pre_dack", bus.dma_request, 1'b1);
        bus.dma_acknowledge_n = 1'b0;
        bus.io_write_n        = 1'b0;
        bus.data_bus_in       = 8'h3C;
        #1;
        check("m1_dir", bus.data_bus_direction, 1'b0);
        tick();
        tick();
        bus.io_write_n  = 1'b1;
        bus.data_bus_in = 8'hFF;
        tick();
        bus.dma_acknowledge_n = 1'b1;
        channel_enable        = 1'b0;
        #1;
        check("m1_drq_after", bus.dma_request, DEMAND);
        check("m1_pop_valid", local_pop_valid, 1'b1);
        check("m1_pop_data", local_pop_data, 8'h3C);
        local_pop_ready = 1'b1;
        tick();
        local_pop_ready = 1'b0;
        #1;
        check("m1_drained", local_pop_valid, 1'b0);

        // Three queued bytes, TC on the second.
        transfer_mode    = 1'b0;
        local_push_valid = 1'b1;
        local_push_data  = 8'h11;
        tick();
        local_push_data = 8'h22;
        tick();
        local_push_data = 8'h33;
        tick();
        local_push_valid = 1'b0;
        channel_enable   = 1'b1;
        wait_drq("tc_drq1");
        dma_read("tc_b1", 1'b0, 8'h11);
        check("tc_gap", bus.dma_request, DEMAND);
        wait_drq("tc_drq2");
        dma_read("tc_b2", 1'b1, 8'h22);
        check("tc_done_pulse", transfer_done, 1'b1);
        check("tc_drq_done", bus.dma_request, 1'b0);
        tick();
        check("tc_done_clear", transfer_done, 1'b0);
        tick();
        check("tc_drq_held0", bus.dma_request, 1'b0);
        check("tc_left_valid", local_pop_valid, 1'b1);
        check("tc_left_data", local_pop_data, 8'h33);
        channel_enable = 1'b0;
        tick();
        channel_enable = 1'b1;
        tick();
        check("tc_drq_rearm", bus.dma_request, 1'b1);
        dma_read("tc_b3", 1'b0, 8'h33);
        check("tc_b3_done", transfer_done, 1'b0);
        check("tc_b3_empty", local_pop_valid, 1'b0);

        // FIFO full boundary: ninth push refused, push+pop at count 8 keeps it full.
        channel_enable   = 1'b0;
        local_push_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            local_push_data = 8'h81 + 8'(i);
            #1;
            check("full_fill_ready", local_push_ready, 1'b1);
            tick();
        end
        local_push_data = 8'h99;
        #1;
        check("full_refuse", local_push_ready, 1'b0);
        tick();
        check("full_refuse_hold", local_push_ready, 1'b0);
        channel_enable = 1'b1;
        wait_drq("full_drq");
        bus.dma_acknowledge_n = 1'b0;
        bus.io_read_n         = 1'b0;
        #1;
        check("full_dout", bus.data_bus_out, 8'h81);
        tick();
        tick();
        bus.io_read_n = 1'b1;
        #1;
        check("full_swap_ready", local_push_ready, 1'b1);
        tick();
        local_push_valid      = 1'b0;
        bus.dma_acknowledge_n = 1'b1;
        channel_enable        = 1'b0;
        #1;
        check("full_still_full", local_push_ready, 1'b0);
        local_pop_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("full_drain", local_pop_data, (i < 7) ? 8'h82 + 8'(i) : 8'h99);
            tick();
        end
        local_pop_ready = 1'b0;
        #1;
        check("full_drain_empty", local_pop_valid, 1'b0);

        // Reset asserted while IOR is low.
        local_push_valid = 1'b1;
        local_push_data  = 8'h5A;
        tick();
        local_push_valid = 1'b0;
        channel_enable   = 1'b1;
        wait_drq("rst_mid_drq");
        bus.dma_acknowledge_n = 1'b0;
        bus.io_read_n         = 1'b0;
        tick();
        check("rst_mid_dir_pre", bus.data_bus_direction, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check("rst_mid_drq", bus.dma_request, 1'b0);
        check("rst_mid_dir", bus.data_bus_direction, 1'b0);
        check("rst_mid_dout", bus.data_bus_out, 8'h00);
        check("rst_mid_empty", local_pop_valid, 1'b0);
        bus.dma_acknowledge_n = 1'b1;
        bus.io_read_n         = 1'b1;
        channel_enable        = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        check("rst_mid_after", bus.dma_request, 1'b0);
        check("rst_mid_push_ready", local_push_ready, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
